// File: rtl/sigma_delta_dac_mc.sv
// Multi-channel 1-bit sigma-delta DAC: double-buffered PCM frames held for OSR
// ticks, a shared click-free mute ramp, and a 1st/2nd-order modulator per channel.
module sigma_delta_dac_mc #(
  parameter int WIDTH       = 16,
  parameter int CHANNELS    = 2,
  parameter int ORDER       = 2,
  parameter int SIGNED_IN   = 1,
  parameter int OSR         = 64,
  parameter int START_MUTED = 1
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      CEN,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      mute,
  output logic [CHANNELS-1:0]       DACout,
  output logic                      muted,
  output logic                      underrun
);
  localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int IW = WIDTH + 3;
  localparam int SW = WIDTH + 5;

  localparam logic [1:0] ST_MUTED     = 2'd0;
  localparam logic [1:0] ST_RAMP_UP   = 2'd1;
  localparam logic [1:0] ST_PLAY      = 2'd2;
  localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

  // Offset-binary frames are converted once, on their way into active.
  localparam logic [CHANNELS*WIDTH-1:0] SIGN_FLIP =
    (SIGNED_IN != 0) ? '0 : {CHANNELS{{1'b1, {(WIDTH-1){1'b0}}}}};

  localparam logic signed [SW-1:0] HALF = SW'(2 ** (WIDTH - 1));
  localparam logic signed [SW-1:0] IMAX = SW'(2 ** (WIDTH + 1) - 1);
  localparam logic signed [SW-1:0] IMIN = -SW'(2 ** (WIDTH + 1));

  logic [CHANNELS*WIDTH-1:0] pending;
  logic [CHANNELS*WIDTH-1:0] active;
  logic                      pending_valid;
  logic [CW-1:0]             osr_cnt;
  logic [1:0]                state;
  logic [8:0]                g;
  logic                      fire;
  logic                      boundary;

  assign in_ready = !pending_valid;
  assign fire     = in_valid && !pending_valid;
  assign boundary = CEN && (osr_cnt == CW'(OSR - 1));
  assign muted    = (state == ST_MUTED);

  function automatic logic signed [IW-1:0] clamp(input logic signed [SW-1:0] v);
    if (v > IMAX) return IMAX[IW-1:0];
    if (v < IMIN) return IMIN[IW-1:0];
    return v[IW-1:0];
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pending       <= '0;
      pending_valid <= 1'b0;
      active        <= '0;
      osr_cnt       <= '0;
      underrun      <= 1'b0;
    end else begin
      underrun <= boundary && !pending_valid;
      if (CEN) osr_cnt <= boundary ? '0 : osr_cnt + CW'(1);
      if (boundary && pending_valid) begin
        active        <= pending ^ SIGN_FLIP;
        pending_valid <= 1'b0;
      end
      // fire and a consuming boundary are exclusive: fire needs pending empty
      if (fire) begin
        pending       <= in_data;
        pending_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= (START_MUTED != 0) ? ST_MUTED : ST_PLAY;
      g     <= (START_MUTED != 0) ? 9'd0 : 9'd256;
    end else if (boundary) begin
      case (state)
        ST_MUTED:   if (!mute) state <= ST_RAMP_UP;
        ST_RAMP_UP: begin
          if (mute) state <= ST_RAMP_DOWN;
          else begin
            g <= g + 9'd1;
            if (g == 9'd255) state <= ST_PLAY;
          end
        end
        ST_PLAY:    if (mute) state <= ST_RAMP_DOWN;
        default: begin
          if (!mute) state <= ST_RAMP_UP;
          else begin
            g <= g - 9'd1;
            if (g == 9'd1) state <= ST_MUTED;
          end
        end
      endcase
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic signed [WIDTH-1:0]  s;
    logic signed [WIDTH-1:0]  sg;
    logic signed [WIDTH+9:0]  s_ext;
    logic signed [WIDTH+9:0]  g_ext;
    logic signed [WIDTH+9:0]  prod;
    logic signed [SW-1:0]     f;
    logic signed [IW-1:0]     i1;
    logic signed [IW-1:0]     i2;
    logic signed [IW-1:0]     i1n;
    logic signed [IW-1:0]     i2n;
    logic                     y;
    logic                     y_next;

    assign s      = active[k*WIDTH +: WIDTH];
    assign s_ext  = {{10{s[WIDTH-1]}}, s};
    assign g_ext  = {{(WIDTH+1){1'b0}}, g};
    assign prod   = s_ext * g_ext;
    assign sg     = WIDTH'(prod >>> 8);
    assign f      = y ? HALF : -HALF;
    assign i1n    = clamp(SW'(i1) + SW'(sg) - f);
    assign i2n    = clamp(SW'(i2) + SW'(i1n) - f);
    assign y_next = (ORDER == 1) ? !i1n[IW-1] : !i2n[IW-1];
    assign DACout[k] = y;

    always_ff @(posedge CLK) begin
      if (RESET) begin
        i1 <= '0;
        i2 <= '0;
        y  <= 1'b0;
      end else if (CEN) begin
        i1 <= i1n;
        i2 <= i2n;
        y  <= y_next;
      end
    end
  end

endmodule
